// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding and
// default address / filter depth constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    localparam logic [6:0] DEF_TARGET_ADDR = 7'h50;
    localparam int         DEF_FILT_CYCLES = 3;

endpackage

// File: rtl/i2c_glitch_filter.sv
// 2-flop synchronizer, stability filter and edge strobes for one pin.
// Ports: CLK, RST_N, pin (raw), level (filtered), rise/fall (1-cycle).
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync    <= 2'b11;
            cnt     <= '0;
            level   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync    <= {sync[0], pin};
            level_q <= level;
            // Count consecutive samples that disagree with the output;
            // any agreeing sample restarts the count.
            if (sync[1] != level) begin
                if (cnt == LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: filters SCL/SDA, matches address, ACKs and
// streams data bytes. Ports: CLK/RST_N, scl_i/sda_i pins, sda_t
// open-drain enable, rx_* byte sink handshake, busy bus flag.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEF_TARGET_ADDR,
    parameter int         FILT_CYCLES = DEF_FILT_CYCLES
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_t,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       full;

    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_scl (
        .CLK   (CLK),
        .RST_N (RST_N),
        .pin   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_sda (
        .CLK   (CLK),
        .RST_N (RST_N),
        .pin   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            full     <= 1'b0;
            sda_t    <= 1'b1;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_start <= 1'b0;
            rx_stop  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_start <= 1'b0;
            rx_stop  <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                full    <= 1'b0;
                sda_t   <= 1'b1;
                busy    <= 1'b1;
            end else if (stop_det) begin
                state   <= IDLE;
                full    <= 1'b0;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                rx_stop <= (state != IDLE) && (state != IGNORE);
            end else begin
                unique case (state)
                    IDLE, IGNORE: begin
                        sda_t <= 1'b1;
                    end
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                full <= 1'b1;
                        end else if (scl_fall && full) begin
                            // Byte complete: decide ACK/NACK as SCL
                            // drops into the 9th clock.
                            full <= 1'b0;
                            if (state == ADDR) begin
                                if (shift[7:1] == TARGET_ADDR && !shift[0]) begin
                                    sda_t    <= 1'b0;
                                    rx_start <= 1'b1;
                                    state    <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (rx_ready) begin
                                sda_t    <= 1'b0;
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                                state    <= DATA_ACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            sda_t <= 1'b1;
                            state <= DATA;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sda_t <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
